pe_start_fifo_srl: RTL and testbench
====================================

# pe_start_fifo_srl

SRL-backed start-token FIFO feeding a `PE_i4xi4_pack_2x2` task in the `Linear_Layer_i4xi4_q` dataflow region. It accepts a start token from the upstream scheduler through an `ap_fifo`-style write port and presents it to the PE's start logic through an `ap_fifo`-style read port. Storage is an internal shift-register array: writes shift in at index 0, and reads address the oldest entry. Full/empty flags and an occupancy count are registered.

## Interface
Parameters:
- `DATA_WIDTH`, 1: token width in bits.
- `ADDR_WIDTH`, 1: read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `DEPTH`, 2: capacity in entries; must be >= 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: rising-edge clock for all state.
- `reset`  in  1: synchronous, active-high reset.
- `if_write_ce`  in  1: write clock enable; qualifies `if_write`.
- `if_write`  in  1: write request.
- `if_din`  in  DATA_WIDTH: write data.
- `if_full_n`  out  1: 1 when the FIFO can accept a write.
- `if_read_ce`  in  1: read clock enable; qualifies `if_read`.
- `if_read`  in  1: read request; consumes the entry currently on `if_dout`.
- `if_dout`  out  DATA_WIDTH: oldest entry (show-ahead).
- `if_empty_n`  out  1: 1 when `if_dout` holds a valid entry.
- `if_num_data_valid`  out  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `if_err`  out  1: present only with `PE_FIFO_ERR_CHK_EN`; sticky protocol-error flag.

## Operation
- push = `if_write & if_write_ce & if_full_n`. pop = `if_read & if_read_ce & if_empty_n`. The flags are the registered values from the current cycle.
- On push, storage shifts: entry[i+1] <= entry[i] for i in 0..DEPTH-2, and entry[0] <= `if_din`. Storage is not reset.
- Count update: push only gives +1; pop only gives -1; push and pop together leave the count unchanged; neither leaves it unchanged.
- Read address = count-1 when count>0, otherwise 0. `if_dout` = entry[read address], combinational from the storage and count registers. `if_dout` is don't-care while `if_empty_n`=0.
- Next-state flags: `if_empty_n` <= (next count != 0); `if_full_n` <= (next count != DEPTH). `if_num_data_valid` = count register.
- Boundary cases:
  - Push and pop with count in 1..DEPTH-1: the shift and the address stay consistent, and the next-oldest entry appears on `if_dout` the following cycle.
  - Write while full is ignored. Read while empty is ignored. Neither changes state.
  - Push and pop together while full: only the pop occurs, because `if_full_n`=0. Push and pop together while empty: only the push occurs.
  - Deasserting a `_ce` input blocks its request entirely.
- Reset, including mid-operation: count <= 0, `if_empty_n` <= 0, `if_full_n` <= 1, `if_err` <= 0. All queued tokens are discarded.

## Timing
- Reset values of all outputs: `if_full_n`=1, `if_empty_n`=0, `if_num_data_valid`=0, `if_err`=0. `if_dout` is undefined.
- Write-to-read latency is 1 cycle: data pushed at edge N is on `if_dout` with `if_empty_n`=1 after edge N.
- `if_full_n` falls after the edge that stores the DEPTH-th entry, and rises after the edge of the first pop from full.
- Throughput is one push and one pop per cycle, sustained, when 0 < count < DEPTH.
- `if_dout` has no output register. The combinational path is count register, then address mux, then `if_dout`.

## Configuration
- `PE_FIFO_ERR_CHK_EN` defined:
  - Port `if_err` exists.
  - It sets to 1, one cycle after any cycle with `if_write & if_write_ce & ~if_full_n` (overflow attempt) or `if_read & if_read_ce & ~if_empty_n` (underflow attempt).
  - It stays 1 until `reset`.
- Not defined: the `if_err` port and its logic are absent. Blocked requests are silently ignored.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4.
- Reset, then idle 3 cycles: `if_full_n`=1, `if_empty_n`=0, `if_num_data_valid`=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles: after the 4th edge `if_full_n`=0 and count=4. Then pop 4: `if_dout` shows 0x11, 0x22, 0x33, 0x44 in order, ending with `if_empty_n`=0.
- At count=2 holding 0x11, 0x22, push 0x55 and pop in the same cycle for 3 cycles with data 0x55, 0x66, 0x77: count stays 2, and the popped sequence is 0x11, 0x22, 0x55.
- When full, write 0x99 with `if_write`=1: it is ignored, and the contents drain as the original 4 values. With `PE_FIFO_ERR_CHK_EN`, `if_err`=1 on the next cycle.
- With `if_write`=1, `if_write_ce`=0 for 5 cycles, and `if_read`=1 while empty: count stays 0, and `if_err` rises only due to the read.
- Push 2 entries, assert `reset` for 1 cycle together with a push: afterwards count=0, `if_empty_n`=0, `if_full_n`=1, `if_err`=0.

Source files
------------

// File: rtl/pe_start_fifo_srl.sv
// pe_start_fifo_srl: shift-register start-token FIFO with show-ahead read; define PE_FIFO_ERR_CHK_EN to add the sticky if_err port
module pe_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`ifdef PE_FIFO_ERR_CHK_EN
  ,
  output logic                  if_err
`endif
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d, count_m1;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  full_n_q, empty_n_q, push, pop;
  always_comb begin
    push     = if_write & if_write_ce & full_n_q;
    pop      = if_read & if_read_ce & empty_n_q;
    count_d  = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    count_m1 = count_q - 1'b1;
    raddr    = (count_q != '0) ? count_m1[ADDR_WIDTH-1:0] : '0;
  end
  // newest entry lands at index 0, so the oldest sits at count-1
  always_ff @(posedge clk)
    if (push) begin
      mem_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  always_ff @(posedge clk)
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= count_d != '0;
      full_n_q  <= count_d != DEPTH_C;
    end
  assign if_dout           = mem_q[raddr];
  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
`ifdef PE_FIFO_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk)
    if (reset) err_q <= 1'b0;
    else err_q <= err_q | (if_write & if_write_ce & ~full_n_q) | (if_read & if_read_ce & ~empty_n_q);
  assign if_err = err_q;
`endif
endmodule

// File: tb/tb_pe_start_fifo_srl.sv
// tb_pe_start_fifo_srl: scoreboard bench for pe_start_fifo_srl at DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4
module tb_pe_start_fifo_srl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
  logic [7:0] if_din = '0, if_dout;
  logic       if_full_n, if_empty_n;
  logic [2:0] if_num_data_valid;
`ifdef PE_FIFO_ERR_CHK_EN
  logic       if_err;
`endif
  int         checks = 0, errors = 0;
  logic [7:0] sb[$];
  logic       did_pop, merr = 1'b0;
  logic [7:0] got_d, exp_d;

  pe_start_fifo_srl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid)
`ifdef PE_FIFO_ERR_CHK_EN
    , .if_err(if_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic rs, w, wce, input logic [7:0] d, input logic r, rce);
    logic push, pop;
    reset = rs; if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
    pop  = r & rce & (sb.size() > 0);
    push = w & wce & (sb.size() < 4);
    did_pop = pop;
    if (pop) begin got_d = if_dout; exp_d = sb[0]; end
    merr = merr | (w & wce & (sb.size() == 4)) | (r & rce & (sb.size() == 0));
    @(posedge clk); #1;
    if (rs) begin sb.delete(); merr = 1'b0; end
    else begin
      if (pop) sb.delete(0);
      if (push) sb.push_back(d);
    end
    reset = 1'b0; if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 0);
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %b exp 1", if_full_n); end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %b exp 0", if_empty_n); end
    checks++; if (if_num_data_valid !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if_num_data_valid); end
`ifdef PE_FIFO_ERR_CHK_EN
    checks++; if (if_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", if_err); end
`endif
  endtask

  task automatic test_fill_drain;
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, v[i], 0, 0);
      checks++; if (if_num_data_valid !== 3'(i+1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", if_num_data_valid, i+1); end
      checks++; if (if_empty_n !== 1'b1) begin errors++; $display("FAIL fill_empty_n got %b exp 1", if_empty_n); end
    end
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL fill_full_n got %b exp 0", if_full_n); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 8'h00, 1, 1);
      checks++; if (!did_pop || got_d !== exp_d || got_d !== v[i]) begin errors++; $display("FAIL drain_data got %h exp %h", got_d, v[i]); end
      checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL drain_full_n got %b exp 1", if_full_n); end
    end
    checks++; if (if_empty_n !== 1'b0 || if_num_data_valid !== 3'd0) begin errors++; $display("FAIL drain_end got empty_n=%b count=%0d exp 0/0", if_empty_n, if_num_data_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] din [3] = '{8'h55, 8'h66, 8'h77};
    logic [7:0] popv [3] = '{8'h11, 8'h22, 8'h55};
    cyc(0, 1, 1, 8'h11, 0, 0);
    cyc(0, 1, 1, 8'h22, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, din[i], 1, 1);
      checks++; if (!did_pop || got_d !== exp_d || got_d !== popv[i]) begin errors++; $display("FAIL b2b_data got %h exp %h", got_d, popv[i]); end
      checks++; if (if_num_data_valid !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", if_num_data_valid); end
    end
    while (sb.size() > 0) begin
      cyc(0, 0, 0, 8'h00, 1, 1);
      checks++; if (got_d !== exp_d) begin errors++; $display("FAIL b2b_drain got %h exp %h", got_d, exp_d); end
    end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL b2b_end_empty_n got %b exp 0", if_empty_n); end
  endtask

  task automatic test_overflow;
    logic [7:0] v [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, v[i], 0, 0);
    cyc(0, 1, 1, 8'h99, 0, 0);
    checks++; if (if_num_data_valid !== 3'd4 || if_full_n !== 1'b0) begin errors++; $display("FAIL ovf_state got count=%0d full_n=%b exp 4/0", if_num_data_valid, if_full_n); end
`ifdef PE_FIFO_ERR_CHK_EN
    checks++; if (if_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", if_err); end
`endif
    cyc(0, 1, 1, 8'h99, 1, 1);
    checks++; if (!did_pop || got_d !== v[0] || got_d !== exp_d) begin errors++; $display("FAIL ovf_popfull got %h exp %h", got_d, v[0]); end
    checks++; if (if_num_data_valid !== 3'd3 || if_full_n !== 1'b1) begin errors++; $display("FAIL ovf_popfull_state got count=%0d full_n=%b exp 3/1", if_num_data_valid, if_full_n); end
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 8'h00, 1, 1);
      checks++; if (got_d !== v[i] || got_d !== exp_d) begin errors++; $display("FAIL ovf_drain got %h exp %h", got_d, v[i]); end
    end
    cyc(1, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_ce_block;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 8'hAA, 1, 0);
      checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin errors++; $display("FAIL ce_block got count=%0d empty_n=%b exp 0/0", if_num_data_valid, if_empty_n); end
`ifdef PE_FIFO_ERR_CHK_EN
      checks++; if (if_err !== 1'b0) begin errors++; $display("FAIL ce_err_early got %b exp 0", if_err); end
`endif
    end
    cyc(0, 1, 0, 8'hAA, 1, 1);
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0) begin errors++; $display("FAIL underflow_state got count=%0d empty_n=%b exp 0/0", if_num_data_valid, if_empty_n); end
`ifdef PE_FIFO_ERR_CHK_EN
    checks++; if (if_err !== merr || if_err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b exp 1", if_err); end
`endif
    cyc(0, 0, 0, 8'h00, 0, 0);
`ifdef PE_FIFO_ERR_CHK_EN
    checks++; if (if_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", if_err); end
`endif
  endtask

  task automatic test_mid_reset;
    cyc(0, 1, 1, 8'h3C, 0, 0);
    cyc(0, 1, 1, 8'h4D, 0, 0);
    checks++; if (if_num_data_valid !== 3'd2) begin errors++; $display("FAIL prereset_count got %0d exp 2", if_num_data_valid); end
    cyc(1, 1, 1, 8'h5E, 0, 0);
    checks++; if (if_num_data_valid !== 3'd0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1) begin errors++; $display("FAIL midreset got count=%0d empty_n=%b full_n=%b exp 0/0/1", if_num_data_valid, if_empty_n, if_full_n); end
`ifdef PE_FIFO_ERR_CHK_EN
    checks++; if (if_err !== 1'b0) begin errors++; $display("FAIL midreset_err got %b exp 0", if_err); end
`endif
    cyc(0, 1, 1, 8'h6F, 0, 0);
    cyc(0, 0, 0, 8'h00, 1, 1);
    checks++; if (!did_pop || got_d !== 8'h6F || got_d !== exp_d) begin errors++; $display("FAIL postreset_data got %h exp 6f", got_d); end
  endtask

  initial begin
    #1;
    test_reset;
    test_fill_drain;
    test_back_to_back;
    test_overflow;
    test_ce_block;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
